// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Purpose  : Output reorder stage of the radix-2 SDF 64-point FFT. Frames
//            arrive in bit-reversed order at up to one sample per cycle. Each
//            frame is buffered in one bank of a ping-pong complex RAM and
//            replayed in natural order through a valid/ready output register,
//            so the consumer may stall without losing data.
//
// Ports    : clk        rising-edge clock
//            rst_n      synchronous active-low reset
//            in_valid   upstream sample valid
//            in_ready   block can accept a sample
//            in_re      sample real part (signed, WIDTH bits)
//            in_im      sample imaginary part (signed, WIDTH bits)
//            bypass     (FFT_REORDER_BYPASS_EN only) frame uses natural-order
//                       addressing; sampled with sample 0 of the frame
//            out_valid  output sample valid
//            out_ready  downstream accepts the sample
//            out_re     output real part
//            out_im     output imaginary part
//            out_last   final (N-1) sample of a frame
//
// Options  : `define FFT_REORDER_BYPASS_EN adds the bypass port.
//
// Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder #(
    parameter int WIDTH = 32,
    parameter int N     = 64,
    parameter int LOG2N = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
`ifdef FFT_REORDER_BYPASS_EN
    input  logic                    bypass,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_last
);

    // Per-bank life cycle
    typedef enum logic [1:0] {
        c_EMPTY    = 2'd0,
        c_FILLING  = 2'd1,
        c_FULL     = 2'd2,
        c_DRAINING = 2'd3
    } bank_state_t;

    localparam logic [LOG2N-1:0] c_PTR_LAST = LOG2N'(N - 1);

    // Storage: bank index is the MSB of the RAM address
    logic [2*WIDTH-1:0] r_mem [2*N];

    bank_state_t        r_bstate [2];
    logic [LOG2N-1:0]   r_wptr;
    logic [LOG2N-1:0]   r_rptr;
    logic               r_wbank;
    logic               r_rbank;
    logic               r_obank;     // bank the word in the output register came from

    logic [LOG2N-1:0]   w_wr_rev;
    logic [LOG2N-1:0]   w_wr_addr;
    logic               w_wr_natural;
    logic               w_out_hs;
    logic               w_free;
    logic               w_wr_open;
    logic               w_wr_en;
    logic               w_rd_avail;
    logic               w_load;
    logic [2*WIDTH-1:0] w_rd_word;

    // Bit-reversed write address
    genvar gi;
    generate
        for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign w_wr_rev[gi] = r_wptr[LOG2N-1-gi];
        end
    endgenerate

`ifdef FFT_REORDER_BYPASS_EN
    // Natural-order flag per bank, captured with sample 0 of each frame.
    // Sample 0 itself uses the live input: address 0 is identical either way,
    // but the flag must be stored for the rest of the frame.
    logic [1:0] r_byp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byp <= 2'b00;
        end else if (w_wr_en && (r_wptr == '0)) begin
            r_byp[r_wbank] <= bypass;
        end
    end

    assign w_wr_natural = (r_wptr == '0) ? bypass : r_byp[r_wbank];
`else
    assign w_wr_natural = 1'b0;
`endif

    assign w_wr_addr = w_wr_natural ? r_wptr : w_wr_rev;

    assign w_out_hs = out_valid && out_ready;
    // The out_last handshake releases the bank that word came from
    assign w_free   = w_out_hs && out_last;

    // The bank being released this cycle may already take its first write:
    // its data has fully left the RAM, so back-to-back input never stalls.
    assign w_wr_open = (r_bstate[r_wbank] == c_EMPTY)   ||
                       (r_bstate[r_wbank] == c_FILLING) ||
                       (w_free && (r_obank == r_wbank));

    assign in_ready = rst_n && w_wr_open;
    assign w_wr_en  = in_valid && in_ready;

    assign w_rd_avail = (r_bstate[r_rbank] == c_FULL) ||
                        (r_bstate[r_rbank] == c_DRAINING);
    assign w_load     = w_rd_avail && (!out_valid || out_ready);

    // Asynchronous array read into the registered output
    assign w_rd_word = r_mem[{r_rbank, r_rptr}];

    // RAM write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wbank, w_wr_addr}] <= {in_re, in_im};
        end
    end

    // Control and output register. Within a cycle the release of one bank,
    // the write of one bank and the load from one bank always touch
    // different banks, except the release/first-write case where the later
    // write assignment (FILLING/FULL) correctly overrides EMPTY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_wbank   <= 1'b0;
            r_rbank   <= 1'b0;
            r_obank   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            for (int b = 0; b < 2; b++) begin
                r_bstate[b] <= c_EMPTY;
            end
        end else begin
            if (w_free) begin
                r_bstate[r_obank] <= c_EMPTY;
            end

            if (w_wr_en) begin
                // N is a power of two, so the pointer wraps to 0 on its own
                r_wptr <= r_wptr + 1'b1;
                if (r_wptr == c_PTR_LAST) begin
                    r_bstate[r_wbank] <= c_FULL;
                    r_wbank           <= ~r_wbank;
                end else begin
                    r_bstate[r_wbank] <= c_FILLING;
                end
            end

            if (w_load) begin
                out_valid         <= 1'b1;
                out_re            <= w_rd_word[2*WIDTH-1:WIDTH];
                out_im            <= w_rd_word[WIDTH-1:0];
                out_last          <= (r_rptr == c_PTR_LAST);
                r_obank           <= r_rbank;
                r_bstate[r_rbank] <= c_DRAINING;
                r_rptr            <= r_rptr + 1'b1;
                if (r_rptr == c_PTR_LAST) begin
                    r_rbank <= ~r_rbank;
                end
            end else if (w_out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_reorder
// Purpose  : Self-checking bench for fft_bitrev_reorder. A frame-level model
//            reorders each accepted frame by bit reversal of the sample index
//            (or keeps natural order for bypassed frames) and the DUT output
//            stream is compared beat by beat against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_reorder;

    localparam int WIDTH = 32;
    localparam int N     = 64;
    localparam int LOG2N = 6;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_re     = '0;
    logic [WIDTH-1:0] in_im     = '0;
    logic             bypass    = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_re;
    logic [WIDTH-1:0] out_im;
    logic             out_last;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
`ifdef FFT_REORDER_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    // ------------------------------------------------------------------
    // Reference model: whole frames, reordered by index arithmetic
    // ------------------------------------------------------------------
    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        bit               last;
    } beat_t;

    typedef struct {
        bit               acc;
        bit               hs;
        bit               vld;
        bit               last;
        bit               rdy;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } obs_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] fr_re [N];
    logic [WIDTH-1:0] fr_im [N];
    int               fr_cnt = 0;
    bit               fr_byp = 1'b0;

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    task automatic model_accept(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im, input bit byp);
        if (fr_cnt == 0) fr_byp = byp;
        fr_re[fr_cnt] = re;
        fr_im[fr_cnt] = im;
        fr_cnt++;
        if (fr_cnt == N) begin
            for (int j = 0; j < N; j++) begin
                beat_t b;
                int    src;
                src    = fr_byp ? j : bitrev(j);
                b.re   = fr_re[src];
                b.im   = fr_im[src];
                b.last = (j == N - 1);
                exp_q.push_back(b);
            end
            fr_cnt = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        fr_cnt = 0;
    endtask

    // One clock: observe at the falling edge, return just after the rising edge
    task automatic cyc(output obs_t o);
        @(negedge clk);
        o.acc  = in_valid && in_ready;
        o.hs   = out_valid && out_ready;
        o.vld  = out_valid;
        o.last = out_last;
        o.rdy  = in_ready;
        o.re   = out_re;
        o.im   = out_im;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(o);
        cyc(o);
        n_cmp++;
        if ({o.vld, o.last, o.rdy} !== 3'b000 || o.re !== '0 || o.im !== '0) begin
            n_bad++;
            $display("FAIL reset_values: vld=%0b last=%0b rdy=%0b re=%0h im=%0h, required all 0",
                     o.vld, o.last, o.rdy, o.re, o.im);
        end
        rst_n = 1'b1;
        cyc(o);
        n_cmp++;
        if (o.rdy !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: in_ready=%0b, required 1", o.rdy);
        end
        n_cmp++;
        if (o.vld !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_valid: out_valid=%0b, required 0", o.vld);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_frame();
        obs_t             o;
        int               sent = 0, got = 0, t_last = -1, t_first = -1;
        logic [WIDTH-1:0] seen [N];
        out_ready = 1'b1; in_valid = 1'b1; in_re = '0; in_im = '0;
        for (int c = 0; c < 400 && got < N; c++) begin
            cyc(o);
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                sent++;
                if (sent == N) t_last = cyc_n;
            end
            if (o.vld && t_first < 0) t_first = cyc_n;
            if (o.hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL single_beat[%0d]: unexpected re=%0h, none expected", got, o.re);
                end else begin
                    if (o.re !== exp_q[0].re || o.im !== exp_q[0].im || o.last !== exp_q[0].last) begin
                        n_bad++;
                        $display("FAIL single_beat[%0d]: got re=%0h im=%0h last=%0b, required re=%0h im=%0h last=%0b",
                                 got, o.re, o.im, o.last, exp_q[0].re, exp_q[0].im, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
                seen[got] = o.re;
                got++;
            end
            in_valid = (sent < N);
            in_re    = WIDTH'(sent);
            in_im    = -WIDTH'(sent);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != N) begin
            n_bad++; $display("FAIL single_count: got %0d beats, required %0d (timeout)", got, N);
        end
        n_cmp++;
        if (t_first - t_last != 2) begin
            n_bad++; $display("FAIL single_latency: first valid %0d cycles after last input, required 2", t_first - t_last);
        end
        if (got == N) begin
            n_cmp++;
            if (seen[1] !== 32 || seen[2] !== 16 || seen[3] !== 48 || seen[63] !== 63) begin
                n_bad++;
                $display("FAIL single_order: beats 1,2,3,63 = %0d,%0d,%0d,%0d, required 32,16,48,63",
                         seen[1], seen[2], seen[3], seen[63]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        obs_t o;
        int   sent = 0, got = 0, drops = 0, gaps = 0;
        bit   started = 1'b0;
        model_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_re = '0; in_im = $urandom;
        for (int c = 0; c < 700 && got < 3*N; c++) begin
            cyc(o);
            if (in_valid && !o.rdy) drops++;
            if (started && !o.vld) gaps++;
            if (o.vld) started = 1'b1;
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                sent++;
            end
            if (o.hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_beat[%0d]: unexpected re=%0h, none expected", got, o.re);
                end else begin
                    if (o.re !== exp_q[0].re || o.im !== exp_q[0].im || o.last !== exp_q[0].last) begin
                        n_bad++;
                        $display("FAIL b2b_beat[%0d]: got re=%0h im=%0h last=%0b, required re=%0h im=%0h last=%0b",
                                 got, o.re, o.im, o.last, exp_q[0].re, exp_q[0].im, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            in_valid = (sent < 3*N);
            in_re    = WIDTH'((sent / N) * 100 + sent % N);
            in_im    = $urandom;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 3*N) begin
            n_bad++; $display("FAIL b2b_count: got %0d beats, required %0d (timeout)", got, 3*N);
        end
        n_cmp++;
        if (drops != 0) begin
            n_bad++; $display("FAIL b2b_in_ready: in_ready low on %0d cycles, required 0", drops);
        end
        n_cmp++;
        if (gaps != 0) begin
            n_bad++; $display("FAIL b2b_contiguous: %0d output gaps, required 0", gaps);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        obs_t             o;
        int               acc_n = 0, late_rdy = 0, moves = 0, got = 0;
        bit               have = 1'b0;
        logic [WIDTH-1:0] held = '0;
        model_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_re = $urandom; in_im = $urandom;
        for (int c = 0; c < 160; c++) begin
            cyc(o);
            if (acc_n >= 2*N && o.rdy) late_rdy++;
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                acc_n++;
            end
            if (have && (!o.vld || o.re !== held)) moves++;
            if (o.vld && !have) begin
                have = 1'b1;
                held = o.re;
            end
            in_re = $urandom;
            in_im = $urandom;
        end
        n_cmp++;
        if (acc_n != 2*N) begin
            n_bad++; $display("FAIL stall_accepted: %0d samples accepted, required %0d", acc_n, 2*N);
        end
        n_cmp++;
        if (late_rdy != 0) begin
            n_bad++; $display("FAIL stall_in_ready: in_ready high on %0d cycles after buffer full, required 0", late_rdy);
        end
        n_cmp++;
        if (o.vld !== 1'b1 || exp_q.size() == 0 || o.re !== exp_q[0].re) begin
            n_bad++; $display("FAIL stall_head: out_valid=%0b re=%0h, required 1 and first beat of frame", o.vld, o.re);
        end
        n_cmp++;
        if (moves != 0) begin
            n_bad++; $display("FAIL stall_hold: output changed on %0d stalled cycles, required 0", moves);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 400 && got < 2*N; c++) begin
            cyc(o);
            if (o.hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL stall_beat[%0d]: unexpected re=%0h, none expected", got, o.re);
                end else begin
                    if (o.re !== exp_q[0].re || o.im !== exp_q[0].im || o.last !== exp_q[0].last) begin
                        n_bad++;
                        $display("FAIL stall_beat[%0d]: got re=%0h im=%0h last=%0b, required re=%0h im=%0h last=%0b",
                                 got, o.re, o.im, o.last, exp_q[0].re, exp_q[0].im, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
        end
        n_cmp++;
        if (got != 2*N || exp_q.size() != 0) begin
            n_bad++; $display("FAIL stall_drain: drained %0d beats, %0d left, required %0d and 0", got, exp_q.size(), 2*N);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_toggle_ready();
        obs_t             o;
        int               sent = 0, got = 0;
        bit               prev_stall = 1'b0;
        logic [WIDTH-1:0] p_re = '0, p_im = '0;
        bit               p_last = 1'b0;
        model_reset();
        in_valid = 1'b1; in_re = $urandom; in_im = $urandom; out_ready = 1'b1;
        for (int c = 0; c < 800 && got < 2*N; c++) begin
            cyc(o);
            if (prev_stall) begin
                n_cmp++;
                if (o.vld !== 1'b1 || o.re !== p_re || o.im !== p_im || o.last !== p_last) begin
                    n_bad++;
                    $display("FAIL toggle_hold: vld=%0b re=%0h im=%0h last=%0b, required 1 %0h %0h %0b",
                             o.vld, o.re, o.im, o.last, p_re, p_im, p_last);
                end
            end
            prev_stall = o.vld && !out_ready;
            p_re = o.re; p_im = o.im; p_last = o.last;
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                sent++;
            end
            if (o.hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL toggle_beat[%0d]: unexpected re=%0h, none expected", got, o.re);
                end else begin
                    if (o.re !== exp_q[0].re || o.im !== exp_q[0].im || o.last !== exp_q[0].last) begin
                        n_bad++;
                        $display("FAIL toggle_beat[%0d]: got re=%0h im=%0h last=%0b, required re=%0h im=%0h last=%0b",
                                 got, o.re, o.im, o.last, exp_q[0].re, exp_q[0].im, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            in_valid  = (sent < 2*N);
            in_re     = $urandom;
            in_im     = $urandom;
            out_ready = ~out_ready;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got != 2*N || exp_q.size() != 0) begin
            n_bad++; $display("FAIL toggle_count: got %0d beats, %0d left, required %0d and 0", got, exp_q.size(), 2*N);
        end
    endtask

    // ------------------------------------------------------------------
    // A full frame is held in the buffer (consumer stalled) and a second
    // frame is 21 samples in when reset hits; both must be discarded.
    task automatic test_reset_midframe();
        obs_t o;
        int   sent = 0, got = 0, stale = 0;
        model_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_re = 500; in_im = $urandom;
        for (int c = 0; c < 300 && sent < N + 21; c++) begin
            cyc(o);
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                sent++;
            end
            in_valid = (sent < N + 21);
            in_re    = (sent < N) ? WIDTH'(500 + sent) : WIDTH'(700 + sent - N);
            in_im    = $urandom;
        end
        rst_n = 1'b0; in_valid = 1'b0;
        cyc(o);
        n_cmp++;
        if (o.rdy !== 1'b0) begin
            n_bad++; $display("FAIL midreset_ready_low: in_ready=%0b during reset, required 0", o.rdy);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        model_reset();
        cyc(o);
        n_cmp++;
        if (o.rdy !== 1'b1 || o.vld !== 1'b0 || o.last !== 1'b0 || o.re !== '0) begin
            n_bad++;
            $display("FAIL midreset_after: rdy=%0b vld=%0b last=%0b re=%0h, required 1 0 0 0", o.rdy, o.vld, o.last, o.re);
        end
        sent = 0;
        in_valid = 1'b1; in_re = 1000; in_im = $urandom;
        for (int c = 0; c < 400 && got < N; c++) begin
            cyc(o);
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                sent++;
            end
            if (o.hs) begin
                if (o.re < 1000 || o.re > 1063) stale++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL midreset_beat[%0d]: unexpected re=%0d, none expected", got, o.re);
                end else begin
                    if (o.re !== exp_q[0].re || o.im !== exp_q[0].im || o.last !== exp_q[0].last) begin
                        n_bad++;
                        $display("FAIL midreset_beat[%0d]: got re=%0d im=%0h last=%0b, required re=%0d im=%0h last=%0b",
                                 got, o.re, o.im, o.last, exp_q[0].re, exp_q[0].im, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            in_valid = (sent < N);
            in_re    = WIDTH'(1000 + sent);
            in_im    = $urandom;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != N || stale != 0) begin
            n_bad++; $display("FAIL midreset_fresh: got %0d beats with %0d stale, required %0d and 0", got, stale, N);
        end
        // Nothing beyond the fresh frame may emerge
        for (int c = 0; c < 8; c++) cyc(o);
        n_cmp++;
        if (o.vld !== 1'b0) begin
            n_bad++; $display("FAIL midreset_idle: out_valid=%0b after fresh frame, required 0", o.vld);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        obs_t o;
        int   sent = 0, got = 0;
        model_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3000 && got < 4*N; c++) begin
            cyc(o);
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                sent++;
            end
            if (o.hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL random_beat[%0d]: unexpected re=%0h, none expected", got, o.re);
                end else begin
                    if (o.re !== exp_q[0].re || o.im !== exp_q[0].im || o.last !== exp_q[0].last) begin
                        n_bad++;
                        $display("FAIL random_beat[%0d]: got re=%0h im=%0h last=%0b, required re=%0h im=%0h last=%0b",
                                 got, o.re, o.im, o.last, exp_q[0].re, exp_q[0].im, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            in_valid  = (sent < 4*N) && ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_re     = $urandom;
            in_im     = $urandom;
`ifdef FFT_REORDER_BYPASS_EN
            bypass    = 1'($urandom_range(0, 1));
`endif
        end
        in_valid = 1'b0; out_ready = 1'b1; bypass = 1'b0;
        n_cmp++;
        if (got != 4*N || exp_q.size() != 0) begin
            n_bad++; $display("FAIL random_count: got %0d beats, %0d left, required %0d and 0", got, exp_q.size(), 4*N);
        end
    endtask

`ifdef FFT_REORDER_BYPASS_EN
    // ------------------------------------------------------------------
    // bypass is driven opposite to the frame setting on every sample but
    // sample 0, so only the value captured with sample 0 may matter.
    task automatic test_bypass();
        obs_t             o;
        int               sent = 0, got = 0;
        logic [WIDTH-1:0] seen [2*N];
        model_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_re = 0; in_im = $urandom; bypass = 1'b1;
        for (int c = 0; c < 500 && got < 2*N; c++) begin
            cyc(o);
            if (o.acc) begin
                model_accept(in_re, in_im, bypass);
                sent++;
            end
            if (o.hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL bypass_beat[%0d]: unexpected re=%0h, none expected", got, o.re);
                end else begin
                    if (o.re !== exp_q[0].re || o.im !== exp_q[0].im || o.last !== exp_q[0].last) begin
                        n_bad++;
                        $display("FAIL bypass_beat[%0d]: got re=%0d im=%0h last=%0b, required re=%0d im=%0h last=%0b",
                                 got, o.re, o.im, o.last, exp_q[0].re, exp_q[0].im, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
                seen[got] = o.re;
                got++;
            end
            in_valid = (sent < 2*N);
            in_re    = WIDTH'((sent / N) * 100 + sent % N);
            in_im    = $urandom;
            if (sent < N) bypass = (sent == 0);
            else          bypass = (sent != N);
        end
        in_valid = 1'b0; bypass = 1'b0;
        n_cmp++;
        if (got != 2*N) begin
            n_bad++; $display("FAIL bypass_count: got %0d beats, required %0d", got, 2*N);
        end else begin
            n_cmp++;
            if (seen[1] !== 1 || seen[2] !== 2 || seen[N+1] !== 132 || seen[N+2] !== 116) begin
                n_bad++;
                $display("FAIL bypass_order: beats 1,2,65,66 = %0d,%0d,%0d,%0d, required 1,2,132,116",
                         seen[1], seen[2], seen[N+1], seen[N+2]);
            end
        end
    endtask
`endif

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_toggle_ready();
        test_reset_midframe();
        test_random();
`ifdef FFT_REORDER_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
